multicycle_controller: RTL and testbench

Sequencing FSM for the multi-cycle RV32I core variant. It steps one shared datapath (single ALU, unified instruction/data memory port) through fetch, decode, execute, memory and writeback phases. It drives every datapath enable and mux select per state and stalls on a memory ready handshake. It sits beside the ALU decoder (driven by `ALUOp`) and the immediate extender (driven by `ImmSrc`).

---
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the shared datapath.
// master: the controller (drives enables/selects); slave: the datapath.
interface multicycle_controller_if #(
  parameter int unsigned OP_WIDTH      = 7,
  parameter int unsigned ALU_OP_WIDTH  = 2,
  parameter int unsigned IMM_SRC_WIDTH = 3
);
  logic [OP_WIDTH-1:0]      op;
  logic                     funct3_0;
  logic                     Zero;
  logic                     mem_ready;
  logic                     AdrSrc;
  logic                     IRWrite;
  logic                     PCWrite;
  logic [1:0]               ALUSrcA;
  logic [1:0]               ALUSrcB;
  logic [ALU_OP_WIDTH-1:0]  ALUOp;
  logic [IMM_SRC_WIDTH-1:0] ImmSrc;
  logic [1:0]               ResultSrc;
  logic                     MemWrite;
  logic                     RegWrite;
  logic                     retire;
  logic                     illegal;

  modport master (
    input  op, funct3_0, Zero, mem_ready,
    output AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ResultSrc,
           MemWrite, RegWrite, retire, illegal
  );

  modport slave (
    output op, funct3_0, Zero, mem_ready,
    input  AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ResultSrc,
           MemWrite, RegWrite, retire, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: steps the shared datapath
// through fetch/decode/execute/memory/writeback and stalls on mem_ready.
module multicycle_controller #(
  parameter int unsigned OP_WIDTH      = 7,
  parameter int unsigned ALU_OP_WIDTH  = 2,
  parameter int unsigned IMM_SRC_WIDTH = 3
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_controller_if.master  bus
);

  localparam logic [OP_WIDTH-1:0] OpLw     = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OpSw     = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OpR      = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OpIAlu   = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OpBranch = OP_WIDTH'(7'b1100011);
  localparam logic [OP_WIDTH-1:0] OpJal    = OP_WIDTH'(7'b1101111);
  localparam logic [OP_WIDTH-1:0] OpLui    = OP_WIDTH'(7'b0110111);
  localparam logic [OP_WIDTH-1:0] OpAuipc  = OP_WIDTH'(7'b0010111);

  localparam logic [ALU_OP_WIDTH-1:0] AluAdd   = ALU_OP_WIDTH'(2'b00);
  localparam logic [ALU_OP_WIDTH-1:0] AluSub   = ALU_OP_WIDTH'(2'b01);
  localparam logic [ALU_OP_WIDTH-1:0] AluFunct = ALU_OP_WIDTH'(2'b10);

  localparam logic [IMM_SRC_WIDTH-1:0] ImmI = IMM_SRC_WIDTH'(3'b000);
  localparam logic [IMM_SRC_WIDTH-1:0] ImmS = IMM_SRC_WIDTH'(3'b001);
  localparam logic [IMM_SRC_WIDTH-1:0] ImmB = IMM_SRC_WIDTH'(3'b010);
  localparam logic [IMM_SRC_WIDTH-1:0] ImmJ = IMM_SRC_WIDTH'(3'b011);
  localparam logic [IMM_SRC_WIDTH-1:0] ImmU = IMM_SRC_WIDTH'(3'b100);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StExecU, StAluWb, StBranch, StJal, StIllegal
  } state_e;

  state_e state_q, state_d;

  logic       adr_src, ir_write, pc_update, branch, take;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       mem_write, reg_write, retire, illegal;
  logic [ALU_OP_WIDTH-1:0]  alu_op;
  logic [IMM_SRC_WIDTH-1:0] imm_src;

  // State register; reset aborts any instruction and returns to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  // Immediate format follows the opcode in every state, including reset.
  always_comb begin
    imm_src = ImmI;
    case (bus.op)
      OpSw:           imm_src = ImmS;
      OpBranch:       imm_src = ImmB;
      OpJal:          imm_src = ImmJ;
      OpLui, OpAuipc: imm_src = ImmU;
      default:        imm_src = ImmI;
    endcase
  end

  // Next state and per-state datapath controls; unlisted selects rest at 0.
  always_comb begin
    state_d    = state_q;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = AluAdd;
    result_src = 2'b00;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    take       = bus.Zero ^ bus.funct3_0;

    unique case (state_q)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch/jal target into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OpLw, OpSw:     state_d = StMemAdr;
          OpR:            state_d = StExecR;
          OpIAlu:         state_d = StExecI;
          OpBranch:       state_d = StBranch;
          OpJal:          state_d = StJal;
          OpLui, OpAuipc: state_d = StExecU;
          default:        state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        // Strobe held through stalls until memory acknowledges.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = bus.mem_ready;
        if (bus.mem_ready) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = AluFunct;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = AluFunct;
        state_d   = StAluWb;
      end
      StExecU: begin
        // lui adds to zero, auipc adds to the instruction's own PC.
        alu_src_a = (bus.op == OpLui) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 2'b10;
        alu_op    = AluSub;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        // Jump to the target precomputed in decode; ALU forms OldPC+4 for rd.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StIllegal: begin
        illegal = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Drive the bus; every write enable is suppressed while reset is held.
  always_comb begin
    bus.AdrSrc    = adr_src;
    bus.ALUSrcA   = alu_src_a;
    bus.ALUSrcB   = alu_src_b;
    bus.ALUOp     = alu_op;
    bus.ImmSrc    = imm_src;
    bus.ResultSrc = result_src;
    bus.IRWrite   = ir_write & ~rst;
    bus.PCWrite   = (pc_update | (branch & take)) & ~rst;
    bus.MemWrite  = mem_write & ~rst;
    bus.RegWrite  = reg_write & ~rst;
    bus.retire    = retire & ~rst;
    bus.illegal   = illegal & ~rst;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per instruction, expected per-cycle control vectors are
// queued with the mem_ready value for that cycle, then drained cycle by cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic       adr, irw, pcw;
    logic [1:0] sa, sb, aop;
    logic [2:0] imm;
    logic [1:0] res;
    logic       mw, rw, ret, ill;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  outs_t      exp_q[$];
  logic       rdy_q[$];
  string      tag_q[$];
  logic [2:0] cur_imm;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %05h required %05h", tag, got, want);
    end
  endtask

  function automatic outs_t mk(logic adr, logic irw, logic pcw, logic [1:0] sa, logic [1:0] sb,
                               logic [1:0] aop, logic [1:0] res, logic mw, logic rw,
                               logic ret, logic ill);
    outs_t o;
    o = '{adr: adr, irw: irw, pcw: pcw, sa: sa, sb: sb, aop: aop, imm: 3'b000, res: res,
          mw: mw, rw: rw, ret: ret, ill: ill};
    return o;
  endfunction

  // Expected controls per state, written out from the state table.
  function automatic outs_t e_fetch(logic r);
    return mk(0, r, r, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_rst();
    return mk(0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_decode();
    return mk(0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_memadr();
    return mk(0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_memread();
    return mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_memwb();
    return mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1, 1, 0);
  endfunction
  function automatic outs_t e_memwrite(logic r);
    return mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, r, 0);
  endfunction
  function automatic outs_t e_execr();
    return mk(0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_execi();
    return mk(0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_execu(logic [1:0] sa);
    return mk(0, 0, 0, sa, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_aluwb();
    return mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0);
  endfunction
  function automatic outs_t e_branch(logic tk);
    return mk(0, 0, tk, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0);
  endfunction
  function automatic outs_t e_jal();
    return mk(0, 0, 1, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic outs_t e_illegal();
    return mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o = '{adr: bus.AdrSrc, irw: bus.IRWrite, pcw: bus.PCWrite, sa: bus.ALUSrcA,
          sb: bus.ALUSrcB, aop: bus.ALUOp, imm: bus.ImmSrc, res: bus.ResultSrc,
          mw: bus.MemWrite, rw: bus.RegWrite, ret: bus.retire, ill: bus.illegal};
    return o;
  endfunction

  task automatic start(input logic [6:0] op, input logic [2:0] imm, input logic f3,
                       input logic z);
    bus.op       = op;
    bus.funct3_0 = f3;
    bus.Zero     = z;
    cur_imm      = imm;
  endtask

  task automatic push(input string tag, input logic rdy, input outs_t e);
    outs_t x;
    x     = e;
    x.imm = cur_imm;
    exp_q.push_back(x);
    rdy_q.push_back(rdy);
    tag_q.push_back(tag);
  endtask

  // Entered just after a rising edge; one expectation per clock cycle.
  task automatic drain();
    while (exp_q.size() > 0) begin
      bus.mem_ready = rdy_q.pop_front();
      @(negedge clk);
      check_eq(tag_q.pop_front(), observe(), exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic alu_instr(input string tag, input logic [6:0] op, input logic [2:0] imm,
                           input outs_t ex);
    start(op, imm, 1'b0, 1'b0);
    push({tag, "_fetch"}, 1'b1, e_fetch(1'b1));
    push({tag, "_decode"}, 1'b1, e_decode());
    push({tag, "_exec"}, 1'b1, ex);
    push({tag, "_wb"}, 1'b1, e_aluwb());
    drain();
  endtask

  initial begin
    bus.op        = 7'b0000011;
    bus.funct3_0  = 1'b0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b1;
    cur_imm       = 3'b000;

    // Reset: enables low even with mem_ready high, FETCH selects, ImmSrc from op.
    #3;
    check_eq("reset_lw", observe(), {e_rst()} | 18'(3'b000 << 8));
    bus.op = 7'b1101111;
    #1;
    cur_imm = 3'b011;
    begin
      outs_t r;
      r     = e_rst();
      r.imm = cur_imm;
      check_eq("reset_imm_jal", observe(), r);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // lw, zero wait: 5 cycles.
    start(7'b0000011, 3'b000, 1'b0, 1'b0);
    push("lw_fetch", 1, e_fetch(1));
    push("lw_decode", 1, e_decode());
    push("lw_memadr", 1, e_memadr());
    push("lw_memread", 1, e_memread());
    push("lw_memwb", 1, e_memwb());
    drain();

    // sw with three stall cycles in MEMWRITE: 7 cycles.
    start(7'b0100011, 3'b001, 1'b0, 1'b0);
    push("sw_fetch", 1, e_fetch(1));
    push("sw_decode", 1, e_decode());
    push("sw_memadr", 1, e_memadr());
    for (int i = 0; i < 3; i++) push("sw_stall", 0, e_memwrite(0));
    push("sw_ack", 1, e_memwrite(1));
    drain();

    // Branch decision: funct3_0/Zero = 0/1, 0/0, 1/0, 1/1 -> take 1,0,1,0.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] fz;
      fz = (i == 0) ? 2'b01 : (i == 1) ? 2'b00 : (i == 2) ? 2'b10 : 2'b11;
      start(7'b1100011, 3'b010, fz[1], fz[0]);
      push("br_fetch", 1, e_fetch(1));
      push("br_decode", 1, e_decode());
      push("br_exec", 1, e_branch((i == 0) || (i == 2)));
      drain();
    end

    // jal: PC loaded in JAL, link written in ALUWB.
    alu_instr("jal", 7'b1101111, 3'b011, e_jal());
    alu_instr("lui", 7'b0110111, 3'b100, e_execu(2'b11));
    alu_instr("auipc", 7'b0010111, 3'b100, e_execu(2'b01));
    alu_instr("rtype", 7'b0110011, 3'b000, e_execr());
    alu_instr("ialu", 7'b0010011, 3'b000, e_execi());

    // lw with a fetch stall and a read stall: 7 cycles.
    start(7'b0000011, 3'b000, 1'b0, 1'b0);
    push("lws_fetch_wait", 0, e_fetch(0));
    push("lws_fetch", 1, e_fetch(1));
    push("lws_decode", 1, e_decode());
    push("lws_memadr", 1, e_memadr());
    push("lws_read_wait", 0, e_memread());
    push("lws_memread", 1, e_memread());
    push("lws_memwb", 1, e_memwb());
    drain();

    // Reset while stalled in MEMWRITE aborts the store.
    start(7'b0100011, 3'b001, 1'b0, 1'b0);
    push("rsw_fetch", 1, e_fetch(1));
    push("rsw_decode", 1, e_decode());
    push("rsw_memadr", 1, e_memadr());
    push("rsw_stall", 0, e_memwrite(0));
    drain();
    bus.mem_ready = 1'b0;
    #2;
    begin
      outs_t m;
      m     = e_memwrite(0);
      m.imm = cur_imm;
      check_eq("rsw_pre_reset", observe(), m);
      rst = 1'b1;
      #1;
      m     = e_rst();
      m.imm = cur_imm;
      check_eq("rsw_in_reset", observe(), m);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    push("rsw_after_wait", 0, e_fetch(0));
    push("rsw_after_fetch", 1, e_fetch(1));
    push("rsw_after_decode", 1, e_decode());
    push("rsw_after_memadr", 1, e_memadr());
    push("rsw_after_ack", 1, e_memwrite(1));
    drain();

    // Illegal opcode: terminal, sticky, no enables regardless of mem_ready.
    start(7'b1111111, 3'b000, 1'b0, 1'b0);
    push("ill_fetch", 1, e_fetch(1));
    push("ill_decode", 1, e_decode());
    for (int i = 0; i < 4; i++) push("ill_hold", 1'(i % 2), e_illegal());
    drain();
    rst = 1'b1;
    #1;
    begin
      outs_t r;
      r     = e_rst();
      r.imm = cur_imm;
      check_eq("ill_reset", observe(), r);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    alu_instr("post_ill_rtype", 7'b0110011, 3'b000, e_execr());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety bound: the run is short; never hang.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
